// File: rtl/ccd_pkg.sv
// Shared types and widths for the CCD pixel capture block.
// Holds the line-state enum, counter widths and the default ADC width.
// The top-level design and its sub-modules import everything from here.
package ccd_pkg;

  localparam int ADC_W_DEF = 12;
  localparam int PIX_CNT_W = 12;
  localparam int DLY_CNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DUMMY  = 2'd1,
    ST_ACTIVE = 2'd2
  } ccd_state_t;

endpackage

// File: rtl/ccd_pixel_capture_if.sv
// Pixel output stream: valid/ready handshake carrying data and line markers.
// master drives valid/data/sol/eol; slave drives ready.
// sol/eol are meaningful only while m_valid is high.
interface ccd_pixel_capture_if #(
  parameter int ADC_W = 12
);
  logic             m_valid;
  logic             m_ready;
  logic [ADC_W-1:0] m_data;
  logic             m_sol;
  logic             m_eol;

  modport master (output m_valid, output m_data, output m_sol, output m_eol, input m_ready);
  modport slave  (input m_valid, input m_data, input m_sol, input m_eol, output m_ready);
endinterface

// File: rtl/ccd_pix_fifo.sv
// Show-ahead FIFO with a registered head word; i_push is dropped when full unless a pop frees a slot.
// Latency: word written at cycle W is visible on o_dout at W+1 when the FIFO was empty.
// Backpressure: head word held stable until i_pop; push rejected silently when full without pop.
module ccd_pix_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_vld;
  logic [WIDTH-1:0] r_dout;

  logic             w_pop;
  logic             w_push;
  logic [PTR_W-1:0] w_rd_ptr_nxt;
  logic [CNT_W-1:0] w_cnt_left;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_pop        = i_pop & r_vld;
  assign o_full       = (r_cnt == CNT_W'(DEPTH));
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_push       = i_push & (~o_full | w_pop);
  assign w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_pop);
  assign w_cnt_left   = r_cnt - CNT_W'(w_pop);
  assign w_cnt_nxt    = w_cnt_left + CNT_W'(w_push);
  assign o_dout       = r_dout;
  assign o_empty      = ~r_vld;

  // Storage write; contents need no reset since r_cnt gates every read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointers, occupancy and the registered head word (bypass when the FIFO drains to empty).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_vld    <= 1'b0;
      r_dout   <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_push);
      r_rd_ptr <= w_rd_ptr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_vld    <= (w_cnt_nxt != '0);
      if (w_cnt_left == '0) begin
        if (w_push) r_dout <= i_din;
      end else begin
        r_dout <= r_mem[w_rd_ptr_nxt];
      end
    end
  end

endmodule

// File: rtl/ccd_pixel_capture.sv
// Samples one ADC word per CCD pixel clock, skips dummy pixels and streams one active line.
// Latency: capture at C, FIFO write at C+1, m_valid at C+2 when the FIFO was empty.
// Backpressure: 8-entry FIFO absorbs stalls; on full the pixel is dropped and overflow sticks.
module ccd_pixel_capture
  import ccd_pkg::*;
#(
  parameter int ADC_W      = ADC_W_DEF,
  parameter int DUMMY_PIX  = 16,
  parameter int ACTIVE_PIX = 128,
  parameter int SAMPLE_DLY = 25,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_cdsclk1,
  input  logic              i_sh,
  input  logic [ADC_W-1:0]  i_adc_data,
  ccd_pixel_capture_if.master m_if,
  output logic              o_overflow,
  output logic              o_line_done,
  output logic              o_line_abort
);

  ccd_state_t           r_state;
  logic                 r_cds_d;
  logic                 r_sh_d;
  logic [DLY_CNT_W-1:0] r_dly;
  logic [PIX_CNT_W-1:0] r_pix_cnt;
  logic                 r_push;
  logic [ADC_W-1:0]     r_push_dat;
  logic                 r_push_sol;
  logic                 r_push_eol;
  logic                 r_line_done;
  logic                 r_line_abort;
  logic                 r_overflow;

  logic                 w_cds_rise;
  logic                 w_sh_rise;
  logic                 w_sh_fall;
  logic                 w_capture;
  logic                 w_pop;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic [ADC_W+1:0]     w_fifo_dout;

  assign w_cds_rise = i_cdsclk1 & ~r_cds_d;
  assign w_sh_rise  = i_sh & ~r_sh_d;
  assign w_sh_fall  = ~i_sh & r_sh_d;
  // Zero delay samples on the edge cycle itself; otherwise the capture fires when
  // the countdown reaches 1, unless a fresh edge restarts the countdown.
  assign w_capture  = (SAMPLE_DLY == 0) ? w_cds_rise
                                        : (~w_cds_rise & (r_dly == DLY_CNT_W'(1)));
  assign w_pop      = m_if.m_ready & ~w_fifo_empty;

  // One-cycle delay of the driver outputs for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cds_d <= 1'b0;
      r_sh_d  <= 1'b0;
    end else begin
      r_cds_d <= i_cdsclk1;
      r_sh_d  <= i_sh;
    end
  end

  // Line FSM with sample-delay counter, pixel counter and registered push/pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_dly        <= '0;
      r_pix_cnt    <= '0;
      r_push       <= 1'b0;
      r_push_dat   <= '0;
      r_push_sol   <= 1'b0;
      r_push_eol   <= 1'b0;
      r_line_done  <= 1'b0;
      r_line_abort <= 1'b0;
    end else begin
      r_push       <= 1'b0;
      r_line_done  <= 1'b0;
      r_line_abort <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          r_dly <= '0;
          if (w_sh_fall) begin
            r_state   <= ST_DUMMY;
            r_pix_cnt <= '0;
          end
        end
        ST_DUMMY, ST_ACTIVE: begin
          if (w_sh_rise) begin
            // Abort: keep whatever already sits in the FIFO, emit no eol.
            r_state      <= ST_IDLE;
            r_line_abort <= 1'b1;
            r_dly        <= '0;
            r_pix_cnt    <= '0;
          end else begin
            if (w_cds_rise)          r_dly <= DLY_CNT_W'(SAMPLE_DLY);
            else if (r_dly != '0)    r_dly <= r_dly - DLY_CNT_W'(1);
            if (w_capture) begin
              if (r_state == ST_DUMMY) begin
                if (r_pix_cnt == PIX_CNT_W'(DUMMY_PIX - 1)) begin
                  r_state   <= ST_ACTIVE;
                  r_pix_cnt <= '0;
                end else begin
                  r_pix_cnt <= r_pix_cnt + PIX_CNT_W'(1);
                end
              end else begin
                r_push     <= 1'b1;
                r_push_dat <= i_adc_data;
                r_push_sol <= (r_pix_cnt == '0);
                r_push_eol <= (r_pix_cnt == PIX_CNT_W'(ACTIVE_PIX - 1));
                if (r_pix_cnt == PIX_CNT_W'(ACTIVE_PIX - 1)) begin
                  r_state     <= ST_IDLE;
                  r_line_done <= 1'b1;
                  r_pix_cnt   <= '0;
                end else begin
                  r_pix_cnt <= r_pix_cnt + PIX_CNT_W'(1);
                end
              end
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky overflow: a push arrived while full and no pop made room.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (r_push & w_fifo_full & ~w_pop) begin
      r_overflow <= 1'b1;
    end
  end

  ccd_pix_fifo #(
    .WIDTH (ADC_W + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_push),
    .i_din   ({r_push_sol, r_push_eol, r_push_dat}),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign m_if.m_valid = ~w_fifo_empty;
  assign m_if.m_data  = w_fifo_dout[ADC_W-1:0];
  assign m_if.m_eol   = w_fifo_dout[ADC_W];
  assign m_if.m_sol   = w_fifo_dout[ADC_W+1];
  assign o_overflow   = r_overflow;
  assign o_line_done  = r_line_done;
  assign o_line_abort = r_line_abort;

endmodule

// File: tb/tb_ccd_pixel_capture.sv
// Directed bench for ccd_pixel_capture: normal, throttled, stalled, aborted and reset lines,
// plus a zero-sample-delay instance. Beats are collected half a cycle after each falling edge
// and compared against hand-derived pixel indices.
`timescale 1ns/1ps
module tb_ccd_pixel_capture;

  logic        clk;
  logic        rst_n;
  logic        cdsclk1, sh;
  logic [11:0] adc_data;
  logic        overflow, line_done, line_abort;
  logic        cds0, sh0;
  logic [11:0] adc0;
  logic        ovf0, done0, abort0;
  logic        tog_en;

  ccd_pixel_capture_if #(.ADC_W(12)) s_if ();
  ccd_pixel_capture_if #(.ADC_W(12)) s_if0 ();

  ccd_pixel_capture #(
    .ADC_W(12), .DUMMY_PIX(16), .ACTIVE_PIX(128), .SAMPLE_DLY(25), .FIFO_DEPTH(8)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .i_cdsclk1(cdsclk1), .i_sh(sh), .i_adc_data(adc_data),
    .m_if(s_if), .o_overflow(overflow), .o_line_done(line_done), .o_line_abort(line_abort)
  );

  ccd_pixel_capture #(
    .ADC_W(12), .DUMMY_PIX(1), .ACTIVE_PIX(4), .SAMPLE_DLY(0), .FIFO_DEPTH(8)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .i_cdsclk1(cds0), .i_sh(sh0), .i_adc_data(adc0),
    .m_if(s_if0), .o_overflow(ovf0), .o_line_done(done0), .o_line_abort(abort0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_cmp = 0;
  int          n_err = 0;
  logic [13:0] beats[$];
  logic [13:0] beats0[$];
  int          n_done = 0, n_abort = 0, n_done0 = 0, n_abort0 = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Beats transferred n from index base: data first+i, sol on the first, eol on the last if has_eol.
  task automatic chk_line(input string tag, input logic [13:0] q[$], input int base,
                          input int n, input int first, input bit has_eol);
    logic [13:0] e;
    logic        s, eo;
    chk({tag, " count"}, 32'(q.size() - base), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (base + i >= q.size()) break;
      s  = (i == 0);
      eo = has_eol && (i == n - 1);
      e  = {s, eo, 12'(first + i)};
      chk($sformatf("%s beat %0d", tag, i), 32'(q[base + i]), 32'(e));
    end
  endtask

  // Collector: sampled just after the falling edge, i.e. the values the next rising edge uses.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (s_if.m_valid && s_if.m_ready) beats.push_back({s_if.m_sol, s_if.m_eol, s_if.m_data});
      if (s_if0.m_valid && s_if0.m_ready) beats0.push_back({s_if0.m_sol, s_if0.m_eol, s_if0.m_data});
      if (line_done)  n_done++;
      if (line_abort) n_abort++;
      if (done0)      n_done0++;
      if (abort0)     n_abort0++;
    end
  end

  // Ready throttle: alternates every cycle while enabled.
  initial begin
    forever begin
      @(negedge clk);
      if (tog_en) s_if.m_ready = ~s_if.m_ready;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, want finish before 2 ms");
    $fatal(1, "watchdog expired");
  end

  task automatic sh_pulse();
    @(negedge clk); sh = 1'b1;
    repeat (100) @(negedge clk);
    sh = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Pixel clock with 40-cycle period; adc_data carries the pixel index since SH fell.
  task automatic pix_clocks(input int n, input int first_idx);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cdsclk1  = 1'b1;
      adc_data = 12'(first_idx + i);
      repeat (20) @(negedge clk);
      cdsclk1 = 1'b0;
      repeat (19) @(negedge clk);
    end
  endtask

  task automatic run_line();
    sh_pulse();
    pix_clocks(144, 0);
    repeat (30) @(negedge clk);
  endtask

  int b, d, a;

  initial begin
    rst_n = 1'b0; cdsclk1 = 1'b0; sh = 1'b0; adc_data = '0;
    cds0 = 1'b0; sh0 = 1'b0; adc0 = '0; tog_en = 1'b0;
    s_if.m_ready = 1'b1; s_if0.m_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst m_valid",    32'(s_if.m_valid), 32'd0);
    chk("rst m_data",     32'(s_if.m_data),  32'd0);
    chk("rst overflow",   32'(overflow),     32'd0);
    chk("rst line_done",  32'(line_done),    32'd0);
    chk("rst line_abort", 32'(line_abort),   32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Zero sample delay: ADC word changes one cycle after the edge; edge-cycle value must win.
    sh0 = 1'b1; repeat (5) @(negedge clk);
    sh0 = 1'b0; repeat (3) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); cds0 = 1'b1; adc0 = 12'(12'hA00 + k);
      @(negedge clk); adc0 = 12'h5A5;
      @(negedge clk); cds0 = 1'b0;
      repeat (3) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    chk_line("dly0", beats0, 0, 4, 12'hA01, 1'b1);
    chk("dly0 line_done", 32'(n_done0), 32'd1);
    chk("dly0 overflow",  32'(ovf0),    32'd0);

    // Normal line, consumer always ready.
    b = beats.size(); d = n_done; a = n_abort;
    run_line();
    chk_line("norm", beats, b, 128, 16, 1'b1);
    chk("norm line_done",  32'(n_done - d),  32'd1);
    chk("norm line_abort", 32'(n_abort - a), 32'd0);
    chk("norm overflow",   32'(overflow),    32'd0);

    // Ready toggling every cycle: full line in order, no overflow.
    b = beats.size(); d = n_done;
    tog_en = 1'b1;
    run_line();
    @(negedge clk); tog_en = 1'b0;
    @(negedge clk); s_if.m_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk_line("toggle", beats, b, 128, 16, 1'b1);
    chk("toggle line_done", 32'(n_done - d), 32'd1);
    chk("toggle overflow",  32'(overflow),   32'd0);

    // Consumer stalled all line: 8 stored, rest dropped, overflow sticky, line_done still fires.
    @(negedge clk); s_if.m_ready = 1'b0;
    b = beats.size(); d = n_done;
    run_line();
    #1;
    chk("stall beats",     32'(beats.size() - b), 32'd0);
    chk("stall line_done", 32'(n_done - d),       32'd1);
    chk("stall overflow",  32'(overflow),         32'd1);
    chk("stall m_valid",   32'(s_if.m_valid),     32'd1);
    chk("stall m_data",    32'(s_if.m_data),      32'd16);
    chk("stall m_sol",     32'(s_if.m_sol),       32'd1);
    chk("stall m_eol",     32'(s_if.m_eol),       32'd0);
    @(negedge clk); s_if.m_ready = 1'b1;
    repeat (20) @(negedge clk);
    chk_line("drain", beats, b, 8, 16, 1'b0);
    chk("drain m_valid", 32'(s_if.m_valid), 32'd0);

    // SH rises after 50 active pixels: abort, no eol, then a complete line.
    b = beats.size(); d = n_done; a = n_abort;
    sh_pulse();
    pix_clocks(66, 0);
    repeat (5) @(negedge clk);
    sh = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort pulse",     32'(n_abort - a), 32'd1);
    chk("abort line_done", 32'(n_done - d),  32'd0);
    chk_line("abort", beats, b, 50, 16, 1'b0);
    b = beats.size(); d = n_done;
    run_line();
    chk_line("post_abort", beats, b, 128, 16, 1'b1);
    chk("post_abort line_done", 32'(n_done - d), 32'd1);

    // Reset in the middle of the active region.
    sh_pulse();
    pix_clocks(46, 0);
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("mid_rst m_valid",    32'(s_if.m_valid), 32'd0);
    chk("mid_rst m_data",     32'(s_if.m_data),  32'd0);
    chk("mid_rst m_sol",      32'(s_if.m_sol),   32'd0);
    chk("mid_rst m_eol",      32'(s_if.m_eol),   32'd0);
    chk("mid_rst overflow",   32'(overflow),     32'd0);
    chk("mid_rst line_done",  32'(line_done),    32'd0);
    chk("mid_rst line_abort", 32'(line_abort),   32'd0);
    @(negedge clk); rst_n = 1'b1;
    b = beats.size(); d = n_done;
    pix_clocks(20, 46);
    repeat (30) @(negedge clk);
    chk("post_rst beats",     32'(beats.size() - b), 32'd0);
    chk("post_rst line_done", 32'(n_done - d),       32'd0);
    b = beats.size(); d = n_done;
    run_line();
    chk_line("post_rst line", beats, b, 128, 16, 1'b1);
    chk("post_rst done",     32'(n_done - d), 32'd1);
    chk("post_rst overflow", 32'(overflow),   32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ccd_pixel_capture.md
# ccd_pixel_capture

Downstream of the CCD timing driver: consumes its cdsclk1 and SH outputs plus the parallel ADC bus, samples one ADC word per CCD pixel clock, discards leading dummy pixels, and emits one line of active pixels as a valid/ready stream with start/end-of-line markers. An 8-entry FIFO absorbs consumer stalls. Overflow and aborted lines are flagged, never hidden.

## Interface
- ADC_W, 12, ADC data width
- DUMMY_PIX, 16, pixels discarded after SH falls (1..255)
- ACTIVE_PIX, 128, pixels delivered per line (1..4095)
- SAMPLE_DLY, 25, clk cycles from cdsclk1 rising edge to ADC capture (0..49)
- FIFO_DEPTH, 8, output FIFO entries (power of 2)

Ports:
- clk  in  1  100 MHz system clock
- rst_n  in  1  reset, asynchronous, active-low
- cdsclk1  in  1  CCD pixel clock from driver, registered in clk domain
- sh  in  1  CCD SH from driver, registered in clk domain
- adc_data  in  ADC_W  ADC output, stable for ≥1 cycle around sample point
- m_valid  out  1  output beat valid
- m_ready  in  1  consumer ready
- m_data  out  ADC_W  pixel value
- m_sol  out  1  first pixel of line (qualified by m_valid)
- m_eol  out  1  last pixel of line (qualified by m_valid)
- overflow  out  1  sticky: active pixel dropped because FIFO full
- line_done  out  1  one-cycle pulse: line completed
- line_abort  out  1  one-cycle pulse: line aborted by SH rise

## Operation
- cdsclk1 and sh already synchronous: no synchronizers; one delay register each for edge detect.
- States: IDLE, DUMMY, ACTIVE.
- IDLE: SH falling edge (sh_d=1, sh=0) → DUMMY, pixel counter 0.
- Capture: cdsclk1 rising edge seen at cycle E loads delay counter; capture of adc_data at cycle E+SAMPLE_DLY. New rising edge while counter running restarts it (old capture lost).
- DUMMY: captures counted, discarded; after DUMMY_PIX captures → ACTIVE, counter 0.
- ACTIVE: each capture pushed to FIFO with sol = (count==0), eol = (count==ACTIVE_PIX-1). After ACTIVE_PIX captures (pushed or dropped) → IDLE, line_done pulse.
- FIFO full on push: word dropped, overflow set; remains set until reset. If the dropped word carried eol, line_done still pulses.
- SH rising edge in DUMMY/ACTIVE: line_abort pulse, → IDLE; FIFO contents kept, no eol generated. SH rising edge in IDLE ignored.
- SH falling edge in DUMMY/ACTIVE: ignored.
- cdsclk1 edges in IDLE ignored; delay counter cleared.
- Counters: pixel counter 12 bits, delay counter 6 bits; no wrap possible within limits.

## Timing
- Capture at C, FIFO write at C+1, m_valid high at C+2 if FIFO was empty (show-ahead, registered outputs).
- Beat transfers when m_valid & m_ready; next word presented following cycle, full throughput 1 beat/cycle.
- m_data/m_sol/m_eol stable while m_valid & !m_ready.
- Simultaneous push and pop with FIFO full: pop frees slot, push accepted, no overflow.
- line_done asserted cycle C+1 of last capture; line_abort cycle after SH edge detection.
- Reset (any time, including mid-line): state IDLE, FIFO emptied, m_valid/m_data/m_sol/m_eol/overflow/line_done/line_abort = 0, counters 0. After release, nothing emitted until next SH falling edge.

## Structure
- ccd_pkg: state enum (IDLE/DUMMY/ACTIVE), counter width constants, default ADC_W.
- Sub-module ccd_pix_fifo: synchronous show-ahead FIFO, width ADC_W+2 (data, sol, eol), full/empty, push/pop.
- Top holds edge detects, delay counter, FSM, pixel counter, flags.

## Test plan
- Driver-like stimulus (cdsclk1 period 100 cycles, SH high frame cycles 501–999, 20000-cycle frame), adc_data = pixel index since SH fall, m_ready=1 → 128 beats, data 16..143, sol on 16, eol on 143, one line_done, overflow 0.
- m_ready=0 whole line → 8 words stored, overflow set at 9th active capture, line_done still pulses; then m_ready=1 → 8 beats data 16..23, sol on first, no eol.
- SH rises after 50 active pixels → line_abort pulse, no eol, 50 beats delivered; next SH fall gives a complete 128-pixel line.
- rst_n low during ACTIVE → all outputs 0 within reset; after release no beats until next SH falling edge, then normal line.
- SAMPLE_DLY=0, adc_data changes one cycle after each cdsclk1 edge → captured values are those present on the edge cycle.
- m_ready toggling 1/0 every cycle → all 128 pixels in order, no overflow.
